// File: rtl/seq_comparator_if.sv
// seq_comparator_if: request/result bundle for the sequential magnitude comparator.
//   master: start, is_signed, A, B out; busy, done, lt, gt, eq in
//   slave : the comparator side (directions reversed)
// WIDTH must match the WIDTH of the attached seq_comparator.
interface seq_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             lt;
  logic             gt;
  logic             eq;

  modport master (
    output start, is_signed, A, B,
    input  busy, done, lt, gt, eq
  );

  modport slave (
    input  start, is_signed, A, B,
    output busy, done, lt, gt, eq
  );
endinterface

// File: rtl/seq_comparator.sv
// seq_comparator: multi-cycle lt/gt/eq magnitude comparator, CHUNK bits per
// clock, most significant chunk first, unsigned or two's-complement.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, priority over everything
//   bus  : seq_comparator_if.slave
//          start/is_signed/A/B sampled when busy=0
//          busy high while a compare runs; done is a one-cycle pulse on which
//          lt/gt/eq are updated; lt/gt/eq hold until the next done.
// Optional build macro SEQ_CMP_EARLY_EXIT_EN: stop on the first differing
// chunk instead of always walking all NCHUNK chunks.
module seq_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_comparator_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDXW-1:0]  idx;
  logic             dec_gt, dec_lt;
  logic             done_q, lt_q, gt_q, eq_q;

  logic [CHUNK-1:0] a_top, b_top;
  logic             new_gt, new_lt, finish;

  // Operands are shifted left each step, so the chunk under test is always
  // the top CHUNK bits; this avoids a variable part-select mux on idx.
  always_comb begin
    state_next = state;
    a_top      = a_q[WIDTH-1 -: CHUNK];
    b_top      = b_q[WIDTH-1 -: CHUNK];
    // First differing chunk decides; later chunks cannot override it.
    new_gt     = dec_gt | (!(dec_gt | dec_lt) & (a_top > b_top));
    new_lt     = dec_lt | (!(dec_gt | dec_lt) & (a_top < b_top));
`ifdef SEQ_CMP_EARLY_EXIT_EN
    finish     = (idx == '0) | new_gt | new_lt;
`else
    finish     = (idx == '0);
`endif
    case (state)
      IDLE: if (bus.start) state_next = RUN;
      RUN:  if (finish)    state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      dec_gt <= 1'b0;
      dec_lt <= 1'b0;
      done_q <= 1'b0;
      lt_q   <= 1'b0;
      gt_q   <= 1'b0;
      eq_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          // Flipping the sign bit maps two's-complement order onto unsigned
          // order, so the chunk walk itself is always unsigned.
          a_q    <= bus.A ^ (bus.is_signed ? MSB_MASK : '0);
          b_q    <= bus.B ^ (bus.is_signed ? MSB_MASK : '0);
          idx    <= IDXW'(NCHUNK - 1);
          dec_gt <= 1'b0;
          dec_lt <= 1'b0;
        end
        RUN: begin
          a_q    <= a_q << CHUNK;
          b_q    <= b_q << CHUNK;
          idx    <= idx - 1'b1;
          dec_gt <= new_gt;
          dec_lt <= new_lt;
          if (finish) begin
            done_q <= 1'b1;
            gt_q   <= new_gt;
            lt_q   <= new_lt;
            eq_q   <= !(new_gt | new_lt);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.lt   = lt_q;
  assign bus.gt   = gt_q;
  assign bus.eq   = eq_q;
endmodule

// File: tb/tb_seq_comparator.sv
// tb_seq_comparator: directed self-checking bench for seq_comparator
// (WIDTH=16, CHUNK=4). Expected latencies follow SEQ_CMP_EARLY_EXIT_EN.
module tb_seq_comparator;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
`ifdef SEQ_CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_comparator_if #(.WIDTH(WIDTH)) bus ();

  seq_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle 1 time unit before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for done, counting edges since the accept edge; bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) chk("timeout", 32'd0, 32'd1);
  endtask

  // Single compare from idle; caller is at #1 after an edge.
  task automatic run_cmp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [2:0] exp_lge, input int exp_lat);
    int lat;
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.is_signed = s;
    step();
    bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_lge"}, 32'({bus.lt, bus.gt, bus.eq}), 32'(exp_lge));
    step();
    chk({tag, "_dpulse"}, 32'({bus.done, bus.busy}), 32'd0);
  endtask

  initial begin
    int lat;
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.A = 16'h1234; bus.B = 16'h0001;

    // 1: reset with start held high
    rst = 1'b1;
    step(); step();
    chk("rst_out", 32'({bus.busy, bus.done, bus.lt, bus.gt, bus.eq}), 32'd0);
    rst = 1'b0; bus.start = 1'b0;
    step(); step();
    chk("rst_idle", 32'({bus.busy, bus.done}), 32'd0);

    // 2: equal operands always take the full walk
    run_cmp("eq",     16'h1234, 16'h1234, 1'b0, 3'b001, 4);
    // 3: sign handling, mismatch in the top chunk
    run_cmp("u_8000", 16'h8000, 16'h7FFF, 1'b0, 3'b010, EE ? 1 : 4);
    run_cmp("s_8000", 16'h8000, 16'h7FFF, 1'b1, 3'b100, EE ? 1 : 4);
    run_cmp("s_m1",   16'hFFFF, 16'h0001, 1'b1, 3'b100, EE ? 1 : 4);
    // 4: mismatch only in the last chunk
    run_cmp("gt_lo",  16'h1235, 16'h1234, 1'b0, 3'b010, 4);
    run_cmp("lt_lo",  16'h1234, 16'h1235, 1'b0, 3'b100, 4);
    // mismatch in the second chunk
    run_cmp("gt_mid", 16'h1334, 16'h1299, 1'b0, 3'b010, EE ? 2 : 4);

    // 5a: start while busy is ignored
    bus.start = 1'b1; bus.A = 16'h0001; bus.B = 16'h0002; bus.is_signed = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1; bus.A = 16'hFFFF; bus.B = 16'h0000;
    step();
    bus.start = 1'b0;
    lat = 0;
    for (int n = 3; n <= 20; n++) begin
      if (bus.done === 1'b1) begin lat = n - 1; break; end
      step();
    end
    if (lat == 0) chk("ign_timeout", 32'd0, 32'd1);
    chk("ign_lat", 32'(lat), 32'd4);
    chk("ign_lge", 32'({bus.lt, bus.gt, bus.eq}), 32'b100);
    step();
    chk("ign_idle", 32'({bus.busy, bus.done}), 32'd0);

    // 5b: reset mid-compare abandons it (clears the held lt=1)
    bus.start = 1'b1; bus.A = 16'h0001; bus.B = 16'h0002;
    step();
    bus.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out", 32'({bus.busy, bus.done, bus.lt, bus.gt, bus.eq}), 32'd0);
    lat = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) lat = 1;
    end
    chk("midrst_nodone", 32'(lat), 32'd0);

    // 6: back-to-back start in the done cycle; old result holds until new done
    bus.start = 1'b1; bus.A = 16'h0001; bus.B = 16'h0002;
    step();
    bus.start = 1'b0;
    wait_done(lat);
    chk("b2b_first", 32'({bus.lt, bus.gt, bus.eq}), 32'b100);
    bus.start = 1'b1; bus.A = 16'h00FF; bus.B = 16'h00FE;
    step();
    bus.start = 1'b0; bus.A = 16'h0000; bus.B = 16'hFFFF;
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (bus.done === 1'b1) begin lat = n - 1; break; end
      chk("b2b_hold", 32'({bus.lt, bus.gt, bus.eq}), 32'b100);
      step();
    end
    if (lat == 0) chk("b2b_timeout", 32'd0, 32'd1);
    chk("b2b_lat", 32'(lat), 32'd4);
    chk("b2b_lge", 32'({bus.lt, bus.gt, bus.eq}), 32'b010);
    step();
    chk("b2b_held", 32'({bus.done, bus.lt, bus.gt, bus.eq}), 32'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
